// File: rtl/read_return_mux.sv
// read_return_mux: returns windowed/extended device read data and fetched instructions, with fault tracking.
// Latency: data 1 cycle after acceptance (2 for LAT2_MASK devices); fetch 1 cycle after fetch_valid.
// Backpressure: req_ready drops for exactly one cycle behind an accepted 2-cycle read; fetch is never stalled.
module read_return_mux #(
    parameter int unsigned      N_DEV      = 8,
    parameter int unsigned      DEV_W      = 3,
    parameter logic [N_DEV-1:0] READ_MASK  = 8'b0011_0011,
    parameter logic [N_DEV-1:0] WRITE_MASK = 8'b0011_0100,
    parameter logic [N_DEV-1:0] FETCH_MASK = 8'b0000_1010,
    parameter logic [N_DEV-1:0] LAT2_MASK  = 8'b0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [DEV_W-1:0]     req_device,
    input  logic [1:0]           req_addr_lo,
    input  logic [1:0]           req_window,
    input  logic                 req_zext,
    input  logic [N_DEV*32-1:0]  rd_data_flat,
    input  logic                 fetch_valid,
    input  logic [DEV_W-1:0]     fetch_device,
    input  logic [N_DEV*32-1:0]  instr_flat,
    output logic [31:0]          data_out,
    output logic                 data_valid,
    output logic [31:0]          instr_out,
    output logic                 instr_valid,
    output logic                 fault_data,
    output logic                 fault_instr,
    input  logic                 fault_clr,
    output logic                 fault_sticky,
    output logic [DEV_W+1:0]     fault_first,
    output logic [15:0]          fault_count
);

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
    localparam logic [1:0]  KIND_BAD   = 2'b00;
    localparam logic [1:0]  KIND_MIS   = 2'b01;
    localparam logic [1:0]  KIND_RSV   = 2'b10;
    localparam logic [1:0]  KIND_FETCH = 2'b11;

    localparam logic [1:0]  WIN_BYTE   = 2'b00;
    localparam logic [1:0]  WIN_HALF   = 2'b01;
    localparam logic [1:0]  WIN_WORD   = 2'b10;
    localparam logic [1:0]  WIN_RSV    = 2'b11;

    // Per-device attribute lookup; device indices beyond N_DEV read as 0 (no permission).
    function automatic logic mask_bit(input logic [N_DEV-1:0] mask, input logic [DEV_W-1:0] dev);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            if (dev == DEV_W'(i)) r = mask[i];
        end
        return r;
    endfunction

    // 32-bit slice of a flattened per-device bus; unknown devices give zero.
    function automatic logic [31:0] slice_of(input logic [N_DEV*32-1:0] flat, input logic [DEV_W-1:0] dev);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            if (dev == DEV_W'(i)) r = flat[i*32 +: 32];
        end
        return r;
    endfunction

    // Captured access attributes, valid from acceptance until the return cycle.
    logic               cap_write_q, cap_write_d;
    logic [DEV_W-1:0]   cap_dev_q,   cap_dev_d;
    logic [1:0]         cap_addr_q,  cap_addr_d;
    logic [1:0]         cap_win_q,   cap_win_d;
    logic               cap_zext_q,  cap_zext_d;

    // pend_q: a 2-cycle read is in its first wait cycle. ret_q: captured access completes this cycle.
    logic               pend_q, pend_d;
    logic               ret_q,  ret_d;

    logic               fetch_vld_q, fetch_vld_d;
    logic [DEV_W-1:0]   fetch_dev_q, fetch_dev_d;

    logic [31:0]        data_hold_q, data_hold_d;
    logic               fault_sticky_q, fault_sticky_d;
    logic [DEV_W+1:0]   fault_first_q,  fault_first_d;
    logic [15:0]        fault_count_q,  fault_count_d;

    logic               accept;
    logic               accept_lat2;
    logic [31:0]        rd_slice;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        windowed;
    logic               rd_bad_dev;
    logic               rd_rsv_win;
    logic               rd_misaligned;
    logic               rd_fault;
    logic               wr_fault;
    logic [1:0]         data_kind;
    logic               fetch_ok;
    logic [1:0]         fault_inc;
    logic [16:0]        count_sum;
    logic [DEV_W+1:0]   fault_sel;

    assign req_ready   = !pend_q;
    assign accept      = req_valid && req_ready;
    assign accept_lat2 = accept && !req_write && mask_bit(LAT2_MASK, req_device);

    // Return-cycle datapath: window, extend and classify the captured access against live device data.
    always_comb begin
        rd_slice = slice_of(rd_data_flat, cap_dev_q);

        case (cap_addr_q)
            2'd0:    byte_sel = rd_slice[7:0];
            2'd1:    byte_sel = rd_slice[15:8];
            2'd2:    byte_sel = rd_slice[23:16];
            default: byte_sel = rd_slice[31:24];
        endcase
        half_sel = cap_addr_q[1] ? rd_slice[31:16] : rd_slice[15:0];

        case (cap_win_q)
            WIN_BYTE: windowed = cap_zext_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            WIN_HALF: windowed = cap_zext_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            WIN_WORD: windowed = rd_slice;
            default:  windowed = '0;
        endcase

        rd_bad_dev    = !mask_bit(READ_MASK, cap_dev_q);
        rd_rsv_win    = (cap_win_q == WIN_RSV);
        rd_misaligned = ((cap_win_q == WIN_HALF) && cap_addr_q[0]) ||
                        ((cap_win_q == WIN_WORD) && (cap_addr_q != 2'd0));
        rd_fault      = rd_bad_dev || rd_rsv_win || rd_misaligned;
        wr_fault      = !mask_bit(WRITE_MASK, cap_dev_q);

        // Writes can only fail on permission, which is reported as a bad-device fault.
        if (cap_write_q || rd_bad_dev) data_kind = KIND_BAD;
        else if (rd_rsv_win)           data_kind = KIND_RSV;
        else                           data_kind = KIND_MIS;
    end

    assign data_valid = ret_q && !cap_write_q;
    assign fault_data = ret_q && (cap_write_q ? wr_fault : rd_fault);
    assign data_out   = data_valid ? (rd_fault ? 32'h0 : windowed) : data_hold_q;

    assign fetch_ok    = mask_bit(FETCH_MASK, fetch_dev_q);
    assign instr_valid = fetch_vld_q;
    assign fault_instr = fetch_vld_q && !fetch_ok;
    assign instr_out   = (fetch_vld_q && fetch_ok) ? slice_of(instr_flat, fetch_dev_q) : INSTR_NOP;

    assign fault_sticky = fault_sticky_q;
    assign fault_first  = fault_first_q;
    assign fault_count  = fault_count_q;

    // Next-state for the access pipeline, fetch stage, held data and fault bookkeeping.
    always_comb begin
        cap_write_d = cap_write_q;
        cap_dev_d   = cap_dev_q;
        cap_addr_d  = cap_addr_q;
        cap_win_d   = cap_win_q;
        cap_zext_d  = cap_zext_q;
        if (accept) begin
            cap_write_d = req_write;
            cap_dev_d   = req_device;
            cap_addr_d  = req_addr_lo;
            cap_win_d   = req_window;
            cap_zext_d  = req_zext;
        end

        // A 2-cycle read parks in pend for one cycle; everything else completes on the next edge.
        pend_d = accept_lat2;
        ret_d  = (accept && !accept_lat2) || pend_q;

        fetch_vld_d = fetch_valid;
        fetch_dev_d = fetch_device;

        data_hold_d = data_valid ? data_out : data_hold_q;

        // When both paths fault together the data-side fault is recorded as the first one.
        fault_sel = fault_data ? {data_kind, cap_dev_q} : {KIND_FETCH, fetch_dev_q};
        fault_inc = {1'b0, fault_data} + {1'b0, fault_instr};
        count_sum = {1'b0, fault_count_q} + {15'b0, fault_inc};

        if (fault_clr) begin
            fault_sticky_d = |fault_inc;
            fault_first_d  = (|fault_inc) ? fault_sel : '0;
            fault_count_d  = {14'b0, fault_inc};
        end else begin
            fault_sticky_d = fault_sticky_q || (|fault_inc);
            fault_first_d  = (!fault_sticky_q && (|fault_inc)) ? fault_sel : fault_first_q;
            fault_count_d  = count_sum[16] ? 16'hFFFF : count_sum[15:0];
        end
    end

    // State registers; reset drops any in-flight access so it never returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_write_q    <= 1'b0;
            cap_dev_q      <= '0;
            cap_addr_q     <= '0;
            cap_win_q      <= '0;
            cap_zext_q     <= 1'b0;
            pend_q         <= 1'b0;
            ret_q          <= 1'b0;
            fetch_vld_q    <= 1'b0;
            fetch_dev_q    <= '0;
            data_hold_q    <= '0;
            fault_sticky_q <= 1'b0;
            fault_first_q  <= '0;
            fault_count_q  <= '0;
        end else begin
            cap_write_q    <= cap_write_d;
            cap_dev_q      <= cap_dev_d;
            cap_addr_q     <= cap_addr_d;
            cap_win_q      <= cap_win_d;
            cap_zext_q     <= cap_zext_d;
            pend_q         <= pend_d;
            ret_q          <= ret_d;
            fetch_vld_q    <= fetch_vld_d;
            fetch_dev_q    <= fetch_dev_d;
            data_hold_q    <= data_hold_d;
            fault_sticky_q <= fault_sticky_d;
            fault_first_q  <= fault_first_d;
            fault_count_q  <= fault_count_d;
        end
    end

endmodule

// File: tb/tb_read_return_mux.sv
// tb_read_return_mux: directed and randomized checks of read_return_mux against a transaction-level model.
// Latency: model predicts outputs cycle by cycle from a queue of accepted accesses tagged with due cycles.
// Backpressure: stimulus holds a request whenever the model predicts req_ready low.
module tb_read_return_mux;

    localparam int          N_DEV      = 8;
    localparam int          DEV_W      = 3;
    localparam logic [7:0]  READ_MASK  = 8'b0011_0011;
    localparam logic [7:0]  WRITE_MASK = 8'b0011_0100;
    localparam logic [7:0]  FETCH_MASK = 8'b0000_1010;
    localparam logic [7:0]  LAT2_MASK  = 8'h10;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [DEV_W-1:0]    req_device;
    logic [1:0]          req_addr_lo;
    logic [1:0]          req_window;
    logic                req_zext;
    logic [N_DEV*32-1:0] rd_data_flat;
    logic                fetch_valid;
    logic [DEV_W-1:0]    fetch_device;
    logic [N_DEV*32-1:0] instr_flat;
    logic [31:0]         data_out;
    logic                data_valid;
    logic [31:0]         instr_out;
    logic                instr_valid;
    logic                fault_data;
    logic                fault_instr;
    logic                fault_clr;
    logic                fault_sticky;
    logic [DEV_W+1:0]    fault_first;
    logic [15:0]         fault_count;

    read_return_mux #(
        .N_DEV(N_DEV), .DEV_W(DEV_W), .READ_MASK(READ_MASK), .WRITE_MASK(WRITE_MASK),
        .FETCH_MASK(FETCH_MASK), .LAT2_MASK(LAT2_MASK)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_device(req_device), .req_addr_lo(req_addr_lo), .req_window(req_window), .req_zext(req_zext),
        .rd_data_flat(rd_data_flat), .fetch_valid(fetch_valid), .fetch_device(fetch_device),
        .instr_flat(instr_flat), .data_out(data_out), .data_valid(data_valid), .instr_out(instr_out),
        .instr_valid(instr_valid), .fault_data(fault_data), .fault_instr(fault_instr),
        .fault_clr(fault_clr), .fault_sticky(fault_sticky), .fault_first(fault_first),
        .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        bit wr;
        int dev;
        int a;
        int win;
        bit zx;
    } acc_t;

    acc_t        mq[$];
    int          cyc      = 0;
    int          blk_cyc  = -1;
    bit          m_fvld   = 0;
    int          m_fdev   = 0;
    bit          m_sticky = 0;
    logic [4:0]  m_first  = '0;
    int          m_count  = 0;
    logic [31:0] m_last   = '0;

    int          hit;
    logic        exp_ready, exp_dv, exp_fd, exp_iv, exp_fi;
    logic [31:0] exp_dout, exp_instr;
    logic [1:0]  exp_kind;
    int          exp_ddev;

    task automatic mdl_eval();
        acc_t        e;
        logic [31:0] slice, v;
        bit          bad, rsv, mis;
        exp_ready = (cyc != blk_cyc);
        exp_dv = 0; exp_fd = 0; exp_kind = 2'b00; exp_ddev = 0; v = '0;
        hit = -1;
        foreach (mq[i]) if (mq[i].due == cyc) hit = i;
        if (hit >= 0) begin
            e = mq[hit];
            exp_ddev = e.dev;
            slice = rd_data_flat[e.dev*32 +: 32];
            if (e.wr) begin
                exp_fd = !WRITE_MASK[e.dev];
            end else begin
                exp_dv = 1;
                bad = !READ_MASK[e.dev];
                rsv = (e.win == 3);
                mis = (e.win == 1 && (e.a % 2) == 1) || (e.win == 2 && e.a != 0);
                case (e.win)
                    0: begin v = (slice >> (8*e.a)) & 32'hFF;
                             if (!e.zx && v[7]) v = v | 32'hFFFF_FF00; end
                    1: begin v = (slice >> (16*(e.a/2))) & 32'hFFFF;
                             if (!e.zx && v[15]) v = v | 32'hFFFF_0000; end
                    2: v = slice;
                    default: v = '0;
                endcase
                exp_fd = bad || rsv || mis;
                if (exp_fd) v = '0;
                exp_kind = bad ? 2'b00 : (rsv ? 2'b10 : 2'b01);
            end
        end
        exp_dout  = exp_dv ? v : m_last;
        exp_iv    = m_fvld;
        exp_fi    = m_fvld && !FETCH_MASK[m_fdev];
        exp_instr = (m_fvld && FETCH_MASK[m_fdev]) ? instr_flat[m_fdev*32 +: 32] : NOP;
    endtask

    task automatic mdl_update();
        acc_t       e;
        int         inc;
        logic [4:0] sel;
        inc = int'(exp_fd) + int'(exp_fi);
        sel = exp_fd ? {exp_kind, 3'(exp_ddev)} : {2'b11, 3'(m_fdev)};
        if (fault_clr) begin
            m_sticky = (inc > 0);
            m_first  = (inc > 0) ? sel : 5'b0;
            m_count  = inc;
        end else begin
            if (inc > 0 && !m_sticky) m_first = sel;
            if (inc > 0) m_sticky = 1;
            m_count = (m_count + inc > 65535) ? 65535 : m_count + inc;
        end
        if (exp_dv) m_last = exp_dout;
        if (hit >= 0) mq.delete(hit);
        if (req_valid && exp_ready) begin
            e.wr = req_write; e.dev = int'(req_device); e.a = int'(req_addr_lo);
            e.win = int'(req_window); e.zx = req_zext;
            if (!req_write && LAT2_MASK[req_device]) begin
                e.due = cyc + 2; blk_cyc = cyc + 1;
            end else begin
                e.due = cyc + 1;
            end
            mq.push_back(e);
        end
        m_fvld = fetch_valid;
        m_fdev = int'(fetch_device);
        if (rst) begin
            mq.delete(); m_fvld = 0; m_sticky = 0; m_first = '0; m_count = 0;
            m_last = '0; blk_cyc = -1;
        end
        cyc++;
    endtask

    task automatic settle();
        #1;
        mdl_eval();
    endtask

    task automatic clock();
        mdl_eval();
        mdl_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_device = '0; req_addr_lo = '0; req_window = '0;
        req_zext = 0; fetch_valid = 0; fetch_device = '0; fault_clr = 0;
    endtask

    task automatic set_read(input int dev, input int a, input int win, input bit zx);
        req_valid = 1; req_write = 0; req_device = 3'(dev); req_addr_lo = 2'(a);
        req_window = 2'(win); req_zext = zx;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1; rd_data_flat = '0; instr_flat = '0;
        @(negedge clk);
        clock(); clock();
        rst = 0;
        settle();
        n_run++;
        if ({req_ready, data_valid, instr_valid, fault_data, fault_instr} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_flags got=%b want=10000",
                               {req_ready, data_valid, instr_valid, fault_data, fault_instr});
        end
        n_run++;
        if (data_out !== 32'h0 || instr_out !== NOP) begin
            n_fail++; $display("FAIL reset_data got data=%h instr=%h want 0/%h", data_out, instr_out, NOP);
        end
        n_run++;
        if ({fault_sticky, fault_first, fault_count} !== 22'h0) begin
            n_fail++; $display("FAIL reset_fault got sticky=%b first=%h count=%h want 0",
                               fault_sticky, fault_first, fault_count);
        end
    endtask

    task automatic test_sign_extend();
        logic [31:0] want [3];
        int          win_t[3], a_t[3];
        bit          zx_t[3];
        want[0] = 32'hFFFF_FF80; win_t[0] = 0; a_t[0] = 3; zx_t[0] = 0;
        want[1] = 32'h0000_0080; win_t[1] = 0; a_t[1] = 3; zx_t[1] = 1;
        want[2] = 32'hFFFF_80AB; win_t[2] = 1; a_t[2] = 2; zx_t[2] = 0;
        rd_data_flat[32*1 +: 32] = 32'h80AB_CD12;
        for (int k = 0; k < 3; k++) begin
            set_read(1, a_t[k], win_t[k], zx_t[k]);
            clock();
            idle_inputs();
            settle();
            n_run++;
            if (data_valid !== 1'b1 || data_out !== want[k] || fault_data !== 1'b0) begin
                n_fail++; $display("FAIL window_%0d got dv=%b data=%h fd=%b want 1/%h/0",
                                   k, data_valid, data_out, fault_data, want[k]);
            end
            clock();
        end
    endtask

    task automatic test_lat2_ready();
        rd_data_flat[32*4 +: 32] = 32'hA4A4_0404;
        rd_data_flat[32*0 +: 32] = 32'hB0B0_0000;
        set_read(4, 0, 2, 0);
        settle();
        n_run++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL lat2_t_ready got=%b want=1", req_ready); end
        clock();
        set_read(0, 0, 2, 0);
        settle();
        n_run++;
        if (req_ready !== 1'b0 || data_valid !== 1'b0) begin
            n_fail++; $display("FAIL lat2_t1 got ready=%b dv=%b want 0/0", req_ready, data_valid);
        end
        clock();
        settle();
        n_run++;
        if (req_ready !== 1'b1 || data_valid !== 1'b1 || data_out !== 32'hA4A4_0404) begin
            n_fail++; $display("FAIL lat2_t2 got ready=%b dv=%b data=%h want 1/1/a4a40404",
                               req_ready, data_valid, data_out);
        end
        clock();
        idle_inputs();
        settle();
        n_run++;
        if (data_valid !== 1'b1 || data_out !== 32'hB0B0_0000) begin
            n_fail++; $display("FAIL lat2_t3 got dv=%b data=%h want 1/b0b00000", data_valid, data_out);
        end
        clock();
    endtask

    task automatic test_bad_device();
        idle_inputs(); clock();
        fault_clr = 1; clock(); fault_clr = 0;
        rd_data_flat[32*2 +: 32] = 32'h1234_5678;
        set_read(2, 0, 2, 0);
        clock();
        idle_inputs();
        settle();
        n_run++;
        if (data_valid !== 1'b1 || data_out !== 32'h0 || fault_data !== 1'b1) begin
            n_fail++; $display("FAIL bad_dev_ret got dv=%b data=%h fd=%b want 1/0/1", data_valid, data_out, fault_data);
        end
        clock();
        settle();
        n_run++;
        if (fault_first !== 5'b00_010 || fault_count !== 16'd1 || fault_sticky !== 1'b1) begin
            n_fail++; $display("FAIL bad_dev_fault got first=%b count=%0d sticky=%b want 00010/1/1",
                               fault_first, fault_count, fault_sticky);
        end
    endtask

    task automatic test_fetch_parallel();
        idle_inputs(); clock();
        fault_clr = 1; clock(); fault_clr = 0;
        rd_data_flat[32*5 +: 32] = 32'h5555_AAAA;
        instr_flat[32*0 +: 32]   = 32'hDEAD_BEEF;
        set_read(5, 0, 2, 1);
        fetch_valid = 1; fetch_device = 3'd0;
        clock();
        idle_inputs();
        settle();
        n_run++;
        if (instr_valid !== 1'b1 || instr_out !== NOP || fault_instr !== 1'b1) begin
            n_fail++; $display("FAIL fetch_bad got iv=%b instr=%h fi=%b want 1/%h/1", instr_valid, instr_out, fault_instr, NOP);
        end
        n_run++;
        if (data_valid !== 1'b1 || data_out !== 32'h5555_AAAA || fault_data !== 1'b0) begin
            n_fail++; $display("FAIL fetch_par_data got dv=%b data=%h fd=%b want 1/5555aaaa/0", data_valid, data_out, fault_data);
        end
        clock();
        settle();
        n_run++;
        if (fault_count !== 16'd1 || fault_first !== 5'b11_000) begin
            n_fail++; $display("FAIL fetch_par_count got count=%0d first=%b want 1/11000", fault_count, fault_first);
        end
        instr_flat[32*1 +: 32] = 32'hC0DE_0001;
        fetch_valid = 1; fetch_device = 3'd1;
        clock();
        idle_inputs();
        settle();
        n_run++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hC0DE_0001 || fault_instr !== 1'b0) begin
            n_fail++; $display("FAIL fetch_ok got iv=%b instr=%h fi=%b want 1/c0de0001/0", instr_valid, instr_out, fault_instr);
        end
        clock();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < N_DEV; d++) begin
                rd_data_flat[d*32 +: 32] = $urandom;
                instr_flat[d*32 +: 32]   = $urandom;
            end
            if (cyc != blk_cyc) begin
                req_valid   = ($urandom_range(0, 3) != 0);
                req_write   = ($urandom_range(0, 3) == 0);
                req_device  = 3'($urandom_range(0, 7));
                req_zext    = 1'($urandom_range(0, 1));
                req_window  = req_write ? 2'd2 : 2'($urandom_range(0, 3));
                req_addr_lo = req_write ? 2'd0 : 2'($urandom_range(0, 3));
            end
            fetch_valid  = 1'($urandom_range(0, 1));
            fetch_device = 3'($urandom_range(0, 7));
            fault_clr    = ($urandom_range(0, 15) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            settle();
            n_run++;
            if ({req_ready, data_valid, fault_data, data_out} !== {exp_ready, exp_dv, exp_fd, exp_dout}) begin
                n_fail++; $display("FAIL rnd_data cyc=%0d got rdy=%b dv=%b fd=%b d=%h want %b/%b/%b/%h",
                                   cyc, req_ready, data_valid, fault_data, data_out, exp_ready, exp_dv, exp_fd, exp_dout);
            end
            n_run++;
            if ({instr_valid, fault_instr, instr_out} !== {exp_iv, exp_fi, exp_instr}) begin
                n_fail++; $display("FAIL rnd_instr cyc=%0d got iv=%b fi=%b i=%h want %b/%b/%h",
                                   cyc, instr_valid, fault_instr, instr_out, exp_iv, exp_fi, exp_instr);
            end
            n_run++;
            if ({fault_sticky, fault_first, fault_count} !== {m_sticky, m_first, 16'(m_count)}) begin
                n_fail++; $display("FAIL rnd_fault cyc=%0d got s=%b f=%b n=%0d want %b/%b/%0d",
                                   cyc, fault_sticky, fault_first, fault_count, m_sticky, m_first, m_count);
            end
            clock();
        end
        rst = 0;
        idle_inputs();
        clock(); clock(); clock();
    endtask

    task automatic test_saturation();
        int guard;
        idle_inputs(); clock();
        fault_clr = 1; clock(); fault_clr = 0;
        set_read(2, 0, 2, 0);
        fetch_valid = 1; fetch_device = 3'd0;
        guard = 0;
        while (m_count < 65535 && guard < 40000) begin
            clock();
            guard++;
        end
        n_run++;
        if (guard >= 40000) begin
            n_fail++; $display("FAIL sat_budget model count=%0d after %0d cycles", m_count, guard);
        end
        clock(); clock();
        settle();
        n_run++;
        if (fault_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_hold got count=%h want ffff", fault_count);
        end
        fetch_valid = 0;
        clock();
        fault_clr = 1;
        settle();
        n_run++;
        if (fault_data !== 1'b1 || fault_instr !== 1'b0) begin
            n_fail++; $display("FAIL clr_setup got fd=%b fi=%b want 1/0", fault_data, fault_instr);
        end
        clock();
        idle_inputs();
        settle();
        n_run++;
        if (fault_count !== 16'd1 || fault_sticky !== 1'b1 || fault_first !== 5'b00_010) begin
            n_fail++; $display("FAIL clr_with_fault got count=%0d sticky=%b first=%b want 1/1/00010",
                               fault_count, fault_sticky, fault_first);
        end
        clock(); clock();
    endtask

    task automatic test_reset_inflight();
        set_read(4, 0, 2, 0);
        clock();
        idle_inputs();
        rst = 1;
        clock();
        rst = 0;
        settle();
        n_run++;
        if ({req_ready, data_valid, instr_valid, fault_data, fault_instr} !== 5'b10000) begin
            n_fail++; $display("FAIL inflight_flags got=%b want=10000",
                               {req_ready, data_valid, instr_valid, fault_data, fault_instr});
        end
        n_run++;
        if (data_out !== 32'h0 || instr_out !== NOP || {fault_sticky, fault_first, fault_count} !== 22'h0) begin
            n_fail++; $display("FAIL inflight_vals got data=%h instr=%h s=%b f=%b n=%0d want 0/%h/0/0/0",
                               data_out, instr_out, fault_sticky, fault_first, fault_count, NOP);
        end
        clock();
        settle();
        n_run++;
        if (data_valid !== 1'b0) begin
            n_fail++; $display("FAIL inflight_late got dv=%b want 0", data_valid);
        end
        clock();
    endtask

    initial begin
        test_reset();
        test_sign_extend();
        test_lat2_ready();
        test_bad_device();
        test_fetch_parallel();
        test_random();
        test_saturation();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
